nand_input_debounce: RTL

//   Front-end conditioning stage for the two NAND operand pins (ui_in[0]=A, ui_in[1]=B).

---
 rtl/nand_input_debounce.sv | 94 +++++++++
 1 files changed

// File: rtl/nand_input_debounce.sv
// Two-channel synchroniser and debouncer for the NAND operand pins, with per-channel change strobes.
// Optional build macro DEBOUNCE_EVENT_CNT_EN adds saturating 8-bit accepted-change counters on evt_cnt.
module nand_input_debounce #(
  parameter int   SYNC_STAGES  = 2,
  parameter int   DEBOUNCE_CYC = 50000,
  parameter int   CNT_W        = 16,
  parameter logic RESET_LEVEL  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  raw_in,
  output logic [1:0]  db_out,
  output logic [1:0]  chg_pulse,
  output logic [1:0]  busy,
  output logic [15:0] evt_cnt
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYC - 1);

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   db_q, db_d;
    logic                   pulse_q, pulse_d;
    logic                   synced;

    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q <= {SYNC_STAGES{RESET_LEVEL}};
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in[ch]};
      end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // Any agreeing edge discards the partial run; only an unbroken run reaching LAST_CNT flips the level.
    always_comb begin
      cnt_d   = '0;
      db_d    = db_q;
      pulse_d = 1'b0;
      if (synced != db_q) begin
        if (cnt_q == LAST_CNT) begin
          db_d    = synced;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q   <= '0;
        db_q    <= RESET_LEVEL;
        pulse_q <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        db_q    <= db_d;
        pulse_q <= pulse_d;
      end
    end

    assign db_out[ch]    = db_q;
    assign chg_pulse[ch] = pulse_q;
    assign busy[ch]      = (cnt_q != '0);

`ifdef DEBOUNCE_EVENT_CNT_EN
    logic [7:0] evt_q, evt_d;

    always_comb begin
      evt_d = evt_q;
      if (pulse_d && (evt_q != 8'hFF)) begin
        evt_d = evt_q + 8'd1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        evt_q <= '0;
      end else begin
        evt_q <= evt_d;
      end
    end

    assign evt_cnt[ch*8 +: 8] = evt_q;
`endif
  end

`ifndef DEBOUNCE_EVENT_CNT_EN
  assign evt_cnt = 16'h0000;
`endif

endmodule
